// File: rtl/kamikaze_fetch_align_pkg.sv
// Shared types and helpers for the kamikaze instruction aligner.
// Decode reuses is_rvc() so both stages agree on what counts as a compressed instruction.
package kamikaze_fetch_align_pkg;

  localparam int ILEN  = 32;
  localparam int HWORD = 16;

  typedef logic [HWORD-1:0] hword_t;

  // How many halfwords of an incoming fetch word enter the queue.
  typedef enum logic [1:0] {
    PUSH_NONE = 2'd0,
    PUSH_ONE  = 2'd1,
    PUSH_TWO  = 2'd2
  } push_e;

  function automatic logic is_rvc(input hword_t h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/kamikaze_hword_queue.sv
// Three-slot halfword shift queue: pop 0/1/2 from slot 0, then append 0/1/2 halfwords.
// PUSH_ONE appends the upper halfword of push_data_i; PUSH_TWO appends both, low first.
module kamikaze_hword_queue
  import kamikaze_fetch_align_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [1:0]  pop_i,
  input  push_e       push_i,
  input  logic [31:0] push_data_i,
  output logic [47:0] data_o,
  output logic [1:0]  cnt_o
);

  logic [47:0] data_q, data_d, shifted;
  logic [1:0]  cnt_q, cnt_d, rem;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    shifted = data_q;
    case (pop_i)
      2'd1:    shifted = {16'h0, data_q[47:16]};
      2'd2:    shifted = {32'h0, data_q[47:32]};
      default: shifted = data_q;
    endcase
    rem    = cnt_q - pop_i;
    data_d = shifted;
    cnt_d  = rem;
    case (push_i)
      PUSH_ONE: begin
        case (rem)
          2'd0:    data_d[15:0]  = push_data_i[31:16];
          2'd1:    data_d[31:16] = push_data_i[31:16];
          2'd2:    data_d[47:32] = push_data_i[31:16];
          default: data_d = shifted;
        endcase
        cnt_d = rem + 2'd1;
      end
      PUSH_TWO: begin
        case (rem)
          2'd0:    data_d[31:0]  = push_data_i;
          2'd1:    data_d[47:16] = push_data_i;
          default: data_d = shifted;
        endcase
        cnt_d = rem + 2'd2;
      end
      default: ;
    endcase
    if (flush_i) cnt_d = 2'd0;
  end

  // NOTE: the halfword storage is reset too, so instr_o reads a defined zero after reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      data_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/kamikaze_fetch_align.sv
// Fetch-word to instruction aligner for RV32IC: rebuilds 16/32-bit instructions across word
// boundaries, tracks their PCs, filters stale fetch words and restarts on redirects.
module kamikaze_fetch_align
  import kamikaze_fetch_align_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] word_i,
  input  logic [31:0] word_addr_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic        is_compressed_instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  localparam logic [31:0] RESET_PC_HW = RESET_PC & ~32'h1;
  localparam logic [31:0] RESET_WORD  = RESET_PC & ~32'h3;

  logic [47:0] q_data;
  logic [1:0]  cnt, used, cnt_rem;
  logic        head_rvc, fire, accept;
  push_e       push;
  logic [31:0] buf_pc, exp_addr;
  logic        skip_lo;

  assign head_rvc      = is_rvc(q_data[15:0]);
  assign instr_valid_o = !rst_i && !redirect_i &&
                         ((cnt >= 2'd2) || (cnt == 2'd1 && head_rvc));
  assign fire          = instr_valid_o && instr_ready_i;
  assign used          = fire ? (head_rvc ? 2'd1 : 2'd2) : 2'd0;
  assign cnt_rem       = cnt - used;

  // Combinational from instr_ready_i so a consumed slot can be refilled in the same cycle.
  assign word_ready_o  = rst_i || redirect_i || (cnt_rem <= 2'd1);
  assign accept        = word_valid_i && word_ready_o && !rst_i && !redirect_i &&
                         (word_addr_i == exp_addr);
  assign push          = !accept ? PUSH_NONE : (skip_lo ? PUSH_ONE : PUSH_TWO);

  assign instr_o               = rst_i    ? 32'h0 :
                                 head_rvc ? {16'h0, q_data[15:0]} : q_data[31:0];
  assign is_compressed_instr_o = rst_i || head_rvc;
  assign pc_o                  = rst_i ? RESET_PC_HW : buf_pc;

  kamikaze_hword_queue u_queue (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .pop_i       (used),
    .push_i      (push),
    .push_data_i (word_i),
    .data_o      (q_data),
    .cnt_o       (cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_pc   <= RESET_PC_HW;
      exp_addr <= RESET_WORD;
      skip_lo  <= RESET_PC[1];
    end else if (redirect_i) begin
      buf_pc   <= redirect_pc_i & ~32'h1;
      exp_addr <= redirect_pc_i & ~32'h3;
      skip_lo  <= redirect_pc_i[1];
    end else begin
      // An empty queue after consumption takes its PC from the word being appended.
      if (accept && cnt_rem == 2'd0)
        buf_pc <= skip_lo ? word_addr_i + 32'd2 : word_addr_i;
      else
        buf_pc <= buf_pc + {29'd0, used, 1'b0};
      if (accept) begin
        exp_addr <= exp_addr + 32'd4;
        skip_lo  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_kamikaze_fetch_align.sv
// Directed bench for kamikaze_fetch_align: aligned, compressed, straddling, backpressure,
// redirect, mid-operation reset and address wrap sequences with hand-computed expectations.
module tb_kamikaze_fetch_align;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] word_i, word_addr_i, redirect_pc_i;
  logic        word_valid_i, redirect_i, instr_ready_i;
  logic        word_ready_o, is_compressed_instr_o, instr_valid_o;
  logic [31:0] instr_o, pc_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  kamikaze_fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .word_i                (word_i),
    .word_addr_i           (word_addr_i),
    .word_valid_i          (word_valid_i),
    .word_ready_o          (word_ready_o),
    .redirect_i            (redirect_i),
    .redirect_pc_i         (redirect_pc_i),
    .instr_o               (instr_o),
    .is_compressed_instr_o (is_compressed_instr_o),
    .pc_o                  (pc_o),
    .instr_valid_o         (instr_valid_o),
    .instr_ready_i         (instr_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic drive(input logic rst, input logic v, input logic [31:0] w, input logic [31:0] a,
                       input logic rdy, input logic redir, input logic [31:0] rpc);
    @(negedge clk_i);
    rst_i         = rst;
    word_valid_i  = v;
    word_i        = w;
    word_addr_i   = a;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                              input logic c);
    check({tag, ".valid"}, {31'd0, instr_valid_o}, 32'd1);
    check({tag, ".instr"}, instr_o, ins);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".rvc"}, {31'd0, is_compressed_instr_o}, {31'd0, c});
  endtask

  initial begin
    rst_i = 1'b1; word_valid_i = 1'b0; word_i = '0; word_addr_i = '0;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;

    // Reset state
    drive(1, 1, 32'h0050_0093, 32'h0, 1, 0, 32'h0);
    drive(1, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    check("rst.valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst.instr", instr_o, 32'h0);
    check("rst.rvc", {31'd0, is_compressed_instr_o}, 32'd1);
    check("rst.pc", pc_o, 32'h0);
    check("rst.wready", {31'd0, word_ready_o}, 32'd1);

    // Aligned 32-bit stream
    drive(0, 1, 32'h0050_0093, 32'h0, 1, 0, 32'h0);
    check("al.empty", {31'd0, instr_valid_o}, 32'd0);
    check("al.wready0", {31'd0, word_ready_o}, 32'd1);
    drive(0, 1, 32'h00A0_0113, 32'h4, 1, 0, 32'h0);
    expect_instr("al0", 32'h0050_0093, 32'h0, 1'b0);
    check("al.wready1", {31'd0, word_ready_o}, 32'd1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("al1", 32'h00A0_0113, 32'h4, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    check("al.drained", {31'd0, instr_valid_o}, 32'd0);

    // Compressed pair from one word
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    check("cp.redir_valid", {31'd0, instr_valid_o}, 32'd0);
    drive(0, 1, 32'h4505_0505, 32'h0, 1, 0, 32'h0);
    check("cp.wready0", {31'd0, word_ready_o}, 32'd1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("cp0", 32'h0000_0505, 32'h0, 1'b1);
    check("cp.wready1", {31'd0, word_ready_o}, 32'd1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("cp1", 32'h0000_4505, 32'h2, 1'b1);
    check("cp.wready2", {31'd0, word_ready_o}, 32'd1);

    // 32-bit instruction straddling a word boundary
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    drive(0, 1, 32'h0093_0505, 32'h0, 1, 0, 32'h0);
    drive(0, 1, 32'h1111_0050, 32'h4, 1, 0, 32'h0);
    expect_instr("st0", 32'h0000_0505, 32'h0, 1'b1);
    check("st.wready", {31'd0, word_ready_o}, 32'd1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("st1", 32'h0050_0093, 32'h2, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("st2", 32'h0000_1111, 32'h6, 1'b1);

    // Backpressure with two buffered halfwords
    drive(0, 1, 32'h00C0_0193, 32'h8, 0, 0, 32'h0);
    check("bp.wready_in", {31'd0, word_ready_o}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h00D0_0213, 32'hC, 0, 0, 32'h0);
      expect_instr("bp.hold", 32'h00C0_0193, 32'h8, 1'b0);
      check("bp.full", {31'd0, word_ready_o}, 32'd0);
    end
    drive(0, 1, 32'h00D0_0213, 32'hC, 1, 0, 32'h0);
    expect_instr("bp.rel0", 32'h00C0_0193, 32'h8, 1'b0);
    check("bp.wready_rel", {31'd0, word_ready_o}, 32'd1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("bp.rel1", 32'h00D0_0213, 32'hC, 1'b0);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    check("bp.nodup", {31'd0, instr_valid_o}, 32'd0);

    // Redirect to a halfword target with stale words in flight
    drive(0, 1, 32'h0000_00F0, 32'h8, 1, 1, 32'h0000_0102);
    check("rd.valid", {31'd0, instr_valid_o}, 32'd0);
    check("rd.wready", {31'd0, word_ready_o}, 32'd1);
    drive(0, 1, 32'h0000_00FC, 32'hC, 1, 0, 32'h0);
    check("rd.stale", {31'd0, instr_valid_o}, 32'd0);
    drive(0, 1, 32'h4505_1234, 32'h100, 1, 0, 32'h0);
    check("rd.stale2", {31'd0, instr_valid_o}, 32'd0);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    expect_instr("rd.tgt", 32'h0000_4505, 32'h102, 1'b1);

    // Fill to three halfwords, then reset mid-operation
    drive(0, 1, 32'h0050_0093, 32'h104, 0, 0, 32'h0);
    check("rs.wready_fill", {31'd0, word_ready_o}, 32'd1);
    drive(0, 1, 32'h0000_0013, 32'h108, 0, 0, 32'h0);
    expect_instr("rs.full", 32'h0000_4505, 32'h102, 1'b1);
    check("rs.wready_full", {31'd0, word_ready_o}, 32'd0);
    drive(1, 1, 32'h00A0_0113, 32'h0, 1, 0, 32'h0);
    check("rs.during_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rs.during_pc", pc_o, 32'h0);
    check("rs.during_wready", {31'd0, word_ready_o}, 32'd1);
    drive(0, 1, 32'h00A0_0113, 32'h0, 1, 0, 32'h0);
    check("rs.after_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rs.after_pc", pc_o, 32'h0);
    check("rs.after_instr", instr_o, 32'h0);
    check("rs.after_wready", {31'd0, word_ready_o}, 32'd1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("rs.first", 32'h00A0_0113, 32'h0, 1'b0);

    // Address wrap from the top of the address space
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'hFFFF_FFFC);
    drive(0, 1, 32'h00B0_0093, 32'hFFFF_FFFC, 1, 0, 32'h0);
    check("wr.empty", {31'd0, instr_valid_o}, 32'd0);
    drive(0, 1, 32'h00C0_0093, 32'h0, 1, 0, 32'h0);
    expect_instr("wr0", 32'h00B0_0093, 32'hFFFF_FFFC, 1'b0);
    check("wr.wready", {31'd0, word_ready_o}, 32'd1);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    expect_instr("wr1", 32'h00C0_0093, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kamikaze_fetch_align.md
# kamikaze_fetch_align

Instruction aligner between the word-fetch stream and `kamikaze_decode`. It accepts word-aligned 32-bit fetch words and buffers up to three halfwords. It emits one complete RV32IC instruction per handshake, either 16-bit compressed or 32-bit, including 32-bit instructions that straddle a word boundary, and tags each with its PC. It also handles control-flow redirects, including redirects to halfword-aligned targets, and discards stale words still in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch PC after reset; halfword aligned.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous and active-high.
- `word_i`  in  32  fetched word, little-endian halfwords.
- `word_addr_i`  in  32  byte address of `word_i`; bits [1:0] are always 0.
- `word_valid_i`  in  1  `word_i`/`word_addr_i` are valid.
- `word_ready_o`  out  1  aligner takes the word this cycle.
- `redirect_i`  in  1  flush and restart at `redirect_pc_i`.
- `redirect_pc_i`  in  32  new PC; bit 0 ignored.
- `instr_o`  out  32  instruction; upper 16 bits = 0 when compressed.
- `is_compressed_instr_o`  out  1  `instr_o[1:0] != 2'b11`.
- `pc_o`  out  32  PC of `instr_o`.
- `instr_valid_o`  out  1  `instr_o` is complete.
- `instr_ready_i`  in  1  decode consumes this cycle.

## Operation
- State:
  - `buf[47:0]`: 3 halfwords; slot 0 is the oldest.
  - `cnt`: 0..3.
  - `buf_pc`: PC of slot 0.
  - `exp_addr`: next expected word address.
  - `skip_lo`: drop the low halfword of the next accepted word.
- Head is compressed when `buf[1:0] != 2'b11`.
- `instr_valid_o` = !`redirect_i` && (`cnt` >= 2 || (`cnt` == 1 && compressed)).
- `instr_o` = compressed ? {16'h0, `buf[15:0]`} : `buf[31:0]`; `pc_o` = `buf_pc`.
- Fire = `instr_valid_o` && `instr_ready_i`. `used` = fire ? (compressed ? 1 : 2) : 0. `cnt_rem` = `cnt` - `used`.
- `word_ready_o` = `redirect_i` || (`cnt_rem` <= 1). The path from `instr_ready_i` to `word_ready_o` is intentionally combinational.
- Word handshake (`word_valid_i` && `word_ready_o`):
  - If `redirect_i`, or `word_addr_i` != `exp_addr`: word discarded, no state change except as below.
  - Otherwise `exp_addr` += 4.
  - If `skip_lo`: only `word_i[31:16]` is appended, `cnt` = `cnt_rem` + 1, `skip_lo` cleared. If the buffer was empty after consume, `buf_pc` = `word_addr_i` + 2.
  - Else both halfwords are appended at slot `cnt_rem`, `cnt` = `cnt_rem` + 2. If empty after consume, `buf_pc` = `word_addr_i`.
- Consumption shifts the buffer down by `used` slots; `buf_pc` += 2·`used` unless reloaded as above.
- Redirect has priority over all other events in the same cycle:
  - `cnt` = 0.
  - `exp_addr` = {`redirect_pc_i[31:2]`, 2'b00}.
  - `skip_lo` = `redirect_pc_i[1]`.
  - `buf_pc` = {`redirect_pc_i[31:1]`, 1'b0}.
  - Any word presented that cycle is dropped.
- Arithmetic: all address math is 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.

## Timing
- Reset: `cnt` = 0, `buf` = 0, `buf_pc` = `RESET_PC`, `exp_addr` = {`RESET_PC[31:2]`, 2'b00}, `skip_lo` = `RESET_PC[1]`.
- Outputs during and after reset: `instr_valid_o` = 0, `instr_o` = 0, `is_compressed_instr_o` = 1, `pc_o` = `RESET_PC`, `word_ready_o` = 1.
- Reset mid-operation discards all buffered halfwords that cycle.
- Latency: a word accepted in cycle N presents its instruction in cycle N+1.
- Throughput: sustained 1 instruction/cycle for aligned 32-bit streams and mixed streams, given `word_valid_i` every cycle. A pure compressed stream yields 2 instructions per accepted word.
- Full: `cnt_rem` = 2 or 3 → `word_ready_o` = 0.
- Empty: `cnt` = 0 → `instr_valid_o` = 0.
- Straddle: `cnt` = 1 with a non-compressed head waits for the next word; `instr_valid_o` stays 0.
- `instr_o`, `pc_o` and `is_compressed_instr_o` are stable while `instr_valid_o` is high and `instr_ready_i` is low.

## Structure
- Add to `riscv_defines.v`: `` `ILEN `` (32), `` `HWORD `` (16), and macro `` `IS_RVC(x) `` (`x[1:0] != 2'b11`) for reuse by decode.
- One sub-module, `kamikaze_hword_queue`: a 3-slot halfword shift queue with a push-2/push-1 port, a pop-0/1/2 port and `cnt`. The top level owns the PC tracking, skip, stale-word filtering and redirect logic.

## Test plan
- Aligned stream, `RESET_PC` = 0: words 0x00500093@0, 0x00A00113@4 with ready held high → instructions on consecutive cycles, `pc_o` 0 then 4, `is_compressed_instr_o` = 0.
- Compressed pair: word 0x00850513... replaced by 0x4505_0505@0 → 0x0505 @pc 0, then 0x4505 @pc 2, both compressed; `word_ready_o` high throughout.
- Straddle: words 0x0093_0505@0 and 0x1111_0050@4 → 0x0505 @0, then 0x00500093 @2, then head 0x1111 @6.
- Backpressure: `instr_ready_i` = 0 for 5 cycles with `cnt` = 2 → outputs stable and `word_ready_o` = 0; release → consumed with no loss or duplication.
- Redirect to 0x102, with stale words 0x0F0@0x8 and 0x0FC@0xC in flight → stale words dropped. Word@0x100 = 0x4505_1234 yields only 0x4505 @pc 0x102. `instr_valid_o` = 0 in the redirect cycle.
- Reset asserted with `cnt` = 3 → next cycle `instr_valid_o` = 0, `pc_o` = `RESET_PC`, first word at `RESET_PC` is accepted normally.
